// File: rtl/cache_port_arbiter_pkg.sv
// Shared definitions for the cache lookup-port arbiter: FSM encoding,
// default sizing and a width helper.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_RESPOND  = 2'd3
    } arb_state_t;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_N_PA_BITS = 32;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cache_port_arbiter_rr_arbiter.sv
// Combinational rotating-priority picker: the first set bit of req at or
// above ptr (wrapping) wins; also reused by the memory-side arbiters.
module rr_arbiter
    import cache_arb_pkg::*;
#(
    parameter int N     = DEF_N_REQ,
    parameter int IDX_W = (clog2(N) > 0) ? clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = IDX_W'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing the cache tag-lookup port among N_REQ
// requesters: one outstanding request, response routed back to its owner.
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int N_PA_BITS  = DEF_N_PA_BITS,
    parameter int N_CNT_BITS = 14,
    localparam int OWNER_W   = (clog2(N_REQ) > 0) ? clog2(N_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_rw,
    input  logic [N_REQ*N_PA_BITS-1:0]  req_addr,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic                        rsp_hit,
    output logic                        cache_req_valid,
    input  logic                        cache_req_ready,
    output logic                        cache_req_rw,
    output logic [N_PA_BITS-1:0]        cache_req_addr,
    input  logic                        cache_rsp_valid,
    input  logic                        cache_rsp_hit,
    output logic                        busy,
    output logic [OWNER_W-1:0]          owner,
    output logic [N_REQ*N_CNT_BITS-1:0] grant_count
);

    arb_state_t           state_reg, state_next;
    logic [OWNER_W-1:0]   rr_ptr_reg;
    logic [OWNER_W-1:0]   owner_reg;
    logic                 rw_reg;
    logic [N_PA_BITS-1:0] addr_reg;
    logic                 hit_reg;

    logic [N_REQ-1:0]     win_gnt;
    logic [OWNER_W-1:0]   win_idx;
    logic                 grant_fire;
    logic [OWNER_W-1:0]   ptr_next;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (OWNER_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr_reg),
        .gnt     (win_gnt),
        .gnt_idx (win_idx)
    );

    // Grants are only offered while idle, so at most one request is in flight.
    assign req_ready  = (state_reg == ST_IDLE) ? win_gnt : '0;
    assign grant_fire = (state_reg == ST_IDLE) && (|(req_valid & req_ready));
    assign ptr_next   = (owner_reg == OWNER_W'(N_REQ - 1)) ? '0 : owner_reg + OWNER_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (grant_fire)      state_next = ST_ISSUE;
            ST_ISSUE:    if (cache_req_ready) state_next = ST_WAIT_RSP;
            ST_WAIT_RSP: if (cache_rsp_valid) state_next = ST_RESPOND;
            ST_RESPOND:                       state_next = ST_IDLE;
            default:                          state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_reg <= '0;
            owner_reg  <= '0;
            rw_reg     <= 1'b0;
            addr_reg   <= '0;
            hit_reg    <= 1'b0;
        end else begin
            if (grant_fire) begin
                owner_reg <= win_idx;
                rw_reg    <= req_rw[win_idx];
                addr_reg  <= req_addr[win_idx*N_PA_BITS +: N_PA_BITS];
            end
            if ((state_reg == ST_WAIT_RSP) && cache_rsp_valid) begin
                hit_reg <= cache_rsp_hit;
            end
            // Pointer moves past the owner only once its response is delivered.
            if (state_reg == ST_RESPOND) begin
                rr_ptr_reg <= ptr_next;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            logic [N_CNT_BITS-1:0] cnt_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_reg <= '0;
                end else if (grant_fire && win_gnt[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + N_CNT_BITS'(1);
                end
            end

            assign grant_count[gi*N_CNT_BITS +: N_CNT_BITS] = cnt_reg;
            assign rsp_valid[gi] = (state_reg == ST_RESPOND) && (owner_reg == OWNER_W'(gi));
        end
    endgenerate

    assign rsp_hit         = (state_reg == ST_RESPOND) && hit_reg;
    assign cache_req_valid = (state_reg == ST_ISSUE);
    assign cache_req_rw    = rw_reg;
    assign cache_req_addr  = addr_reg;
    assign busy            = (state_reg != ST_IDLE);
    assign owner           = owner_reg;

endmodule
